mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Sits between the EX/MEM register and the WB stage.
- Issues data-cache requests for loads and stores, and stalls the pipeline until the cache responds.
- Aligns store data and byte enables, and right-aligns load data. The WB stage sign/zero-extends from bit 0.
- Owns the MEM/WB pipeline register and two performance counters.

Parameters:
COUNTER_W, 32, width of the perf counters (wrap modulo 2^COUNTER_W)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
MEM_valid_in  in  1  EX/MEM holds a real instruction
MEM_ctrl_in  in  rv32i_control_word  control word; uses mem_read, mem_write, funct3, load_regfile
MEM_alu_in  in  32  ALU result; effective address for loads/stores
MEM_rs2_in  in  32  store data
MEM_rd_in  in  5  destination register
MEM_pc_in  in  32  instruction PC
MEM_u_imm_in  in  32  U-type immediate
dmem_read  out  1  cache read request
dmem_write  out  1  cache write request
dmem_address  out  32  {MEM_alu_in[31:2],2'b00}
dmem_wdata  out  32  shifted store data
dmem_byte_enable  out  4  store byte mask
dmem_rdata  in  32  cache read data
dmem_resp  in  1  cache done, one-cycle pulse
MEM_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
WB_valid  out  1  MEM/WB valid
WB_ctrl  out  rv32i_control_word  MEM/WB control
WB_alu  out  32  MEM/WB ALU result
WB_mem  out  32  MEM/WB right-aligned load data
WB_rd  out  5  MEM/WB rd
WB_pc  out  32  MEM/WB PC
WB_u_imm  out  32  MEM/WB U-immediate
WB_misaligned  out  1  MEM/WB misaligned-access flag
perf_mem_ops  out  COUNTER_W  completed memory accesses
perf_stall_cycles  out  COUNTER_W  cycles with MEM_stall=1

Behaviour:
- Reset: all WB_* outputs, both perf counters and the FSM are cleared (FSM to IDLE). dmem_read, dmem_write and MEM_stall are forced to 0 while rst=1.
- off = MEM_alu_in[1:0].
- mem_op = MEM_valid_in & (mem_read | mem_write) & ~misaligned.
- misaligned: funct3=010 with off!=0, or funct3 in {001,101} with off[0]=1.
- Misaligned handling:
  - No cache request is made and there is no stall.
  - The instruction passes to WB with WB_misaligned=1 and WB_ctrl.load_regfile=0.
- Store enables:
  - sb (000): 4'b0001<<off
  - sh (001): 4'b0011<<off
  - sw (010): 4'b1111
  - dmem_wdata = MEM_rs2_in<<(8*off)
  - dmem_byte_enable = 0 when not storing.
- Load data: WB_mem captures dmem_rdata>>(8*off).
- FSM has two states, IDLE and BUSY.
  - IDLE, mem_op=0: no request, MEM_stall=0, and the MEM/WB register loads on every edge.
  - IDLE, mem_op=1: dmem_read/dmem_write driven combinationally this cycle.
    - If dmem_resp=1 in the same cycle: MEM_stall=0, MEM/WB loads, stay IDLE.
    - Otherwise: MEM_stall=1, MEM/WB loads a bubble (WB_valid=0, WB_ctrl=0), go to BUSY.
  - BUSY: request, address, wdata and byte_enable are held. EX/MEM inputs are stable because of the stall. MEM_stall=1 and a bubble goes to WB.
    - On dmem_resp: MEM_stall=0, MEM/WB loads the instruction with load data, go to IDLE.
- MEM_stall = mem_op & ~dmem_resp, irrespective of state.
- Request deassertion: the request drops for at least zero cycles between back-to-back ops. A new instruction may issue in the cycle after a response.
- dmem_resp arriving in IDLE with mem_op=0 is ignored.
- Non-memory instructions (valid, no mem op): pass through in 1 cycle with WB_mem=0.
- MEM_valid_in=0: WB_valid=0 and WB_ctrl=0.
- perf_mem_ops increments on each cycle where mem_op & dmem_resp.
- perf_stall_cycles increments on each cycle where MEM_stall=1.
- Both counters wrap.
- rst asserted in BUSY: the request drops immediately, the FSM goes to IDLE, and no WB update occurs. The cache sees an abandoned request, which is legal for our cache.

Decomposition:
- rv32i_types (shared package) holds rv32i_control_word, the load/store funct3 enums (lb/lh/lw/lbu/lhu, sb/sh/sw) and the FSM state enum.
- Submodule mem_align holds the combinational misalignment check, byte-enable/wdata shift and load right-shift. It is reused by later cache-bypass work.
- The FSM, MEM/WB register and counters stay in mem_stage.

Test Plan:
- sw x, addr 0x100, rs2=0xDEADBEEF, dmem_resp after 3 cycles.
  - Required: dmem_write=1, byte_enable=1111, wdata=0xDEADBEEF.
  - Required: MEM_stall=1 for 3 cycles, then WB_valid=1.
  - Required: perf_stall_cycles=3, perf_mem_ops=1.
- lb, addr 0x103, rdata=0x80112233, resp same cycle.
  - Required: no stall, dmem_address=0x100, WB_mem=0x00000080.
- sh, addr 0x102, rs2=0x0000ABCD.
  - Required: byte_enable=1100, wdata=0xABCD0000.
- lw, addr 0x101.
  - Required: no request, no stall, WB_misaligned=1, WB_ctrl.load_regfile=0.
- Back-to-back lw/lw, each resp after 1 cycle.
  - Required: second request asserted the cycle after the first resp; both values reach WB in order.
- rst asserted mid-BUSY.
  - Required: dmem_read=0 the same cycle, MEM_stall=0, WB outputs=0, FSM=IDLE after rst deasserts.

Source files
------------

// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
//   Shared RV32I pipeline types: the control word that travels down the
//   pipeline registers, the load/store funct3 encodings and the MEM-stage
//   FSM state encoding.
// ---------------------------------------------------------------------------
package rv32i_types;

    // Control word carried from decode through to write-back.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
        logic       load_regfile;
        logic [2:0] regfilemux_sel;
    } rv32i_control_word;

    localparam int unsigned CTRL_W = $bits(rv32i_control_word);

    // Load funct3 encodings.
    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    // Store funct3 encodings.
    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    // MEM-stage access FSM.
    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align
//   Purely combinational alignment helper for data-memory accesses.
//   Ports:
//     funct3       in   access width/sign encoding
//     offset       in   byte offset within the word (address[1:0])
//     is_mem       in   a valid load or store is present
//     is_store     in   a valid store is present
//     store_data   in   unshifted store data (rs2)
//     load_raw     in   word read from the data cache
//     misaligned   out  access crosses its natural alignment
//     byte_enable  out  store byte mask, zero unless an aligned store
//     wdata        out  store data shifted into its byte lane
//     load_data    out  load data right-aligned to bit 0
// ---------------------------------------------------------------------------
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_mem,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic        misaligned,
    output logic [3:0]  byte_enable,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic       width_fault;
    logic [4:0] shamt;

    assign shamt = {offset, 3'b000};

    // Word accesses need offset 0, halfword accesses need an even offset.
    // Load and store encodings agree on width, so one check serves both.
    always_comb begin
        width_fault = 1'b0;
        case (funct3)
            lw:      width_fault = (offset != 2'b00);
            lh, lhu: width_fault = offset[0];
            default: width_fault = 1'b0;
        endcase
    end

    assign misaligned = is_mem & width_fault;

    always_comb begin
        byte_enable = 4'b0000;
        if (is_store && !misaligned) begin
            case (funct3)
                sb:      byte_enable = 4'b0001 << offset;
                sh:      byte_enable = 4'b0011 << offset;
                sw:      byte_enable = 4'b1111;
                default: byte_enable = 4'b0000;
            endcase
        end
    end

    assign wdata     = store_data << shamt;
    assign load_data = load_raw >> shamt;

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   MEM stage of the 5-stage RV32I pipeline. Issues data-cache requests,
//   stalls upstream until the cache responds, aligns store/load data, and
//   owns the MEM/WB pipeline register plus two performance counters.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     MEM_*_in                 EX/MEM register contents
//     dmem_*                   data-cache request / response
//     MEM_stall                freeze PC, IF/ID, ID/EX and EX/MEM
//     WB_*                     MEM/WB register contents
//     perf_mem_ops             completed memory accesses (wraps)
//     perf_stall_cycles        cycles with MEM_stall asserted (wraps)
// ---------------------------------------------------------------------------
module mem_stage
    import rv32i_types::*;
#(
    parameter int unsigned COUNTER_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 MEM_valid_in,
    input  rv32i_control_word    MEM_ctrl_in,
    input  logic [31:0]          MEM_alu_in,
    input  logic [31:0]          MEM_rs2_in,
    input  logic [4:0]           MEM_rd_in,
    input  logic [31:0]          MEM_pc_in,
    input  logic [31:0]          MEM_u_imm_in,

    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic [31:0]          dmem_address,
    output logic [31:0]          dmem_wdata,
    output logic [3:0]           dmem_byte_enable,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_resp,

    output logic                 MEM_stall,

    output logic                 WB_valid,
    output rv32i_control_word    WB_ctrl,
    output logic [31:0]          WB_alu,
    output logic [31:0]          WB_mem,
    output logic [4:0]           WB_rd,
    output logic [31:0]          WB_pc,
    output logic [31:0]          WB_u_imm,
    output logic                 WB_misaligned,

    output logic [COUNTER_W-1:0] perf_mem_ops,
    output logic [COUNTER_W-1:0] perf_stall_cycles
);

    logic        is_mem;
    logic        is_store;
    logic        misaligned;
    logic        mem_op;
    logic [31:0] load_data;

    mem_state_t  state_q, state_d;

    logic              wb_valid_d;
    rv32i_control_word wb_ctrl_d;
    logic [31:0]       wb_alu_d;
    logic [31:0]       wb_mem_d;
    logic [4:0]        wb_rd_d;
    logic [31:0]       wb_pc_d;
    logic [31:0]       wb_u_imm_d;
    logic              wb_misaligned_d;

    logic [COUNTER_W-1:0] mem_ops_inc;
    logic [COUNTER_W-1:0] stall_inc;

    // ---------------------------------------------------------------------
    // Access qualification and alignment
    // ---------------------------------------------------------------------
    assign is_mem   = MEM_valid_in & (MEM_ctrl_in.mem_read | MEM_ctrl_in.mem_write);
    assign is_store = MEM_valid_in & MEM_ctrl_in.mem_write;
    assign mem_op   = is_mem & ~misaligned;

    mem_align u_mem_align (
        .funct3      (MEM_ctrl_in.funct3),
        .offset      (MEM_alu_in[1:0]),
        .is_mem      (is_mem),
        .is_store    (is_store),
        .store_data  (MEM_rs2_in),
        .load_raw    (dmem_rdata),
        .misaligned  (misaligned),
        .byte_enable (dmem_byte_enable),
        .wdata       (dmem_wdata),
        .load_data   (load_data)
    );

    // ---------------------------------------------------------------------
    // Cache request and stall. EX/MEM is frozen while stalled, so driving
    // these straight from the EX/MEM contents holds them through BUSY.
    // Reset masks them so an in-flight request is abandoned immediately.
    // ---------------------------------------------------------------------
    assign dmem_address = {MEM_alu_in[31:2], 2'b00};
    assign dmem_read    = ~rst & mem_op & MEM_ctrl_in.mem_read;
    assign dmem_write   = ~rst & mem_op & MEM_ctrl_in.mem_write;
    assign MEM_stall    = ~rst & mem_op & ~dmem_resp;

    // ---------------------------------------------------------------------
    // FSM: tracks whether an access is outstanding across cycles.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (mem_op && !dmem_resp) state_d = MEM_BUSY;
            MEM_BUSY: if (dmem_resp || !mem_op) state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // MEM/WB next value: a bubble while stalled or when EX/MEM is empty.
    // ---------------------------------------------------------------------
    always_comb begin
        wb_valid_d      = 1'b0;
        wb_ctrl_d       = '0;
        wb_alu_d        = '0;
        wb_mem_d        = '0;
        wb_rd_d         = '0;
        wb_pc_d         = '0;
        wb_u_imm_d      = '0;
        wb_misaligned_d = 1'b0;
        if (MEM_valid_in && !MEM_stall) begin
            wb_valid_d      = 1'b1;
            wb_ctrl_d       = MEM_ctrl_in;
            wb_alu_d        = MEM_alu_in;
            wb_rd_d         = MEM_rd_in;
            wb_pc_d         = MEM_pc_in;
            wb_u_imm_d      = MEM_u_imm_in;
            wb_misaligned_d = misaligned;
            // A faulting access must not write the register file.
            if (misaligned) begin
                wb_ctrl_d.load_regfile = 1'b0;
            end
            if (mem_op && MEM_ctrl_in.mem_read) begin
                wb_mem_d = load_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_valid      <= 1'b0;
            WB_ctrl       <= '0;
            WB_alu        <= '0;
            WB_mem        <= '0;
            WB_rd         <= '0;
            WB_pc         <= '0;
            WB_u_imm      <= '0;
            WB_misaligned <= 1'b0;
        end else begin
            WB_valid      <= wb_valid_d;
            WB_ctrl       <= wb_ctrl_d;
            WB_alu        <= wb_alu_d;
            WB_mem        <= wb_mem_d;
            WB_rd         <= wb_rd_d;
            WB_pc         <= wb_pc_d;
            WB_u_imm      <= wb_u_imm_d;
            WB_misaligned <= wb_misaligned_d;
        end
    end

    // ---------------------------------------------------------------------
    // Performance counters (wrap naturally).
    // ---------------------------------------------------------------------
    assign mem_ops_inc = {{(COUNTER_W-1){1'b0}}, mem_op & dmem_resp};
    assign stall_inc   = {{(COUNTER_W-1){1'b0}}, MEM_stall};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_mem_ops      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_mem_ops      <= perf_mem_ops + mem_ops_inc;
            perf_stall_cycles <= perf_stall_cycles + stall_inc;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Directed scenarios followed by randomized traffic, all checked against a
//   cycle-level reference model of the MEM stage written from access sizes
//   and byte offsets.
// ---------------------------------------------------------------------------
module tb_mem_stage;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              MEM_valid_in;
    rv32i_control_word MEM_ctrl_in;
    logic [31:0]       MEM_alu_in;
    logic [31:0]       MEM_rs2_in;
    logic [4:0]        MEM_rd_in;
    logic [31:0]       MEM_pc_in;
    logic [31:0]       MEM_u_imm_in;
    logic              dmem_read;
    logic              dmem_write;
    logic [31:0]       dmem_address;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_byte_enable;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;
    logic              MEM_stall;
    logic              WB_valid;
    rv32i_control_word WB_ctrl;
    logic [31:0]       WB_alu;
    logic [31:0]       WB_mem;
    logic [4:0]        WB_rd;
    logic [31:0]       WB_pc;
    logic [31:0]       WB_u_imm;
    logic              WB_misaligned;
    logic [31:0]       perf_mem_ops;
    logic [31:0]       perf_stall_cycles;

    always #5 clk = ~clk;

    mem_stage #(.COUNTER_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .MEM_valid_in      (MEM_valid_in),
        .MEM_ctrl_in       (MEM_ctrl_in),
        .MEM_alu_in        (MEM_alu_in),
        .MEM_rs2_in        (MEM_rs2_in),
        .MEM_rd_in         (MEM_rd_in),
        .MEM_pc_in         (MEM_pc_in),
        .MEM_u_imm_in      (MEM_u_imm_in),
        .dmem_read         (dmem_read),
        .dmem_write        (dmem_write),
        .dmem_address      (dmem_address),
        .dmem_wdata        (dmem_wdata),
        .dmem_byte_enable  (dmem_byte_enable),
        .dmem_rdata        (dmem_rdata),
        .dmem_resp         (dmem_resp),
        .MEM_stall         (MEM_stall),
        .WB_valid          (WB_valid),
        .WB_ctrl           (WB_ctrl),
        .WB_alu            (WB_alu),
        .WB_mem            (WB_mem),
        .WB_rd             (WB_rd),
        .WB_pc             (WB_pc),
        .WB_u_imm          (WB_u_imm),
        .WB_misaligned     (WB_misaligned),
        .perf_mem_ops      (perf_mem_ops),
        .perf_stall_cycles (perf_stall_cycles)
    );

    int num_tests = 0;
    int num_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_tests++;
        if (obs !== exp) begin
            num_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic              exp_valid;
    rv32i_control_word exp_ctrl;
    logic [31:0]       exp_alu, exp_mem, exp_pc, exp_uimm;
    logic [4:0]        exp_rd;
    logic              exp_mis;
    logic              exp_live;
    logic [31:0]       exp_ops, exp_stalls;
    logic              exp_stall;

    task automatic model_reset();
        exp_valid  = 1'b0;
        exp_ctrl   = '0;
        exp_alu    = '0;
        exp_mem    = '0;
        exp_pc     = '0;
        exp_uimm   = '0;
        exp_rd     = '0;
        exp_mis    = 1'b0;
        exp_live   = 1'b1;
        exp_ops    = '0;
        exp_stalls = '0;
        exp_stall  = 1'b0;
    endtask

    task automatic check_wb();
        logic [CTRL_W-1:0] obs_c;
        logic [CTRL_W-1:0] exp_c;
        obs_c = WB_ctrl;
        exp_c = exp_ctrl;
        check_eq("wb_valid", 32'(WB_valid), 32'(exp_valid));
        check_eq("wb_ctrl", 32'(obs_c), 32'(exp_c));
        if (exp_live) begin
            check_eq("wb_alu", WB_alu, exp_alu);
            check_eq("wb_mem", WB_mem, exp_mem);
            check_eq("wb_rd", 32'(WB_rd), 32'(exp_rd));
            check_eq("wb_pc", WB_pc, exp_pc);
            check_eq("wb_u_imm", WB_u_imm, exp_uimm);
            check_eq("wb_misaligned", 32'(WB_misaligned), 32'(exp_mis));
        end
        check_eq("perf_mem_ops", perf_mem_ops, exp_ops);
        check_eq("perf_stall_cycles", perf_stall_cycles, exp_stalls);
    endtask

    // One clock cycle; called just after a rising edge with inputs applied.
    task automatic step();
        int unsigned off, sz;
        logic is_mem, mis, mop, is_ld, is_st;
        off    = MEM_alu_in % 4;
        sz     = 1 << MEM_ctrl_in.funct3[1:0];
        is_mem = MEM_valid_in && (MEM_ctrl_in.mem_read || MEM_ctrl_in.mem_write);
        mis    = is_mem && ((MEM_alu_in % sz) != 0);
        mop    = is_mem && !mis;
        is_ld  = mop && MEM_ctrl_in.mem_read;
        is_st  = mop && MEM_ctrl_in.mem_write;
        exp_stall = mop && !dmem_resp;

        #4;
        check_eq("dmem_read", 32'(dmem_read), 32'(is_ld));
        check_eq("dmem_write", 32'(dmem_write), 32'(is_st));
        check_eq("mem_stall", 32'(MEM_stall), 32'(exp_stall));
        if (mop) check_eq("dmem_address", dmem_address, MEM_alu_in - off);
        if (is_st) begin
            check_eq("byte_enable", 32'(dmem_byte_enable), ((32'd1 << sz) - 1) << off);
            check_eq("dmem_wdata", dmem_wdata, MEM_rs2_in << (8 * off));
        end else begin
            check_eq("byte_enable_idle", 32'(dmem_byte_enable), 32'd0);
        end

        if (!MEM_valid_in || exp_stall) begin
            exp_valid = 1'b0;
            exp_ctrl  = '0;
            exp_live  = 1'b0;
        end else begin
            exp_valid = 1'b1;
            exp_live  = 1'b1;
            exp_ctrl  = MEM_ctrl_in;
            if (mis) exp_ctrl.load_regfile = 1'b0;
            exp_alu   = MEM_alu_in;
            exp_mem   = is_ld ? (dmem_rdata >> (8 * off)) : 32'd0;
            exp_rd    = MEM_rd_in;
            exp_pc    = MEM_pc_in;
            exp_uimm  = MEM_u_imm_in;
            exp_mis   = mis;
        end
        if (mop && dmem_resp) exp_ops++;
        if (exp_stall) exp_stalls++;

        @(posedge clk);
        #1;
        check_wb();
    endtask

    // Present one instruction and hold it until the model says it retired.
    // The cache answers after 'lat' wait cycles.
    task automatic drive_op(input logic v, input logic rd_op, input logic wr_op,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [31:0] rdata_v,
                            input int lat);
        rv32i_control_word c;
        c                = '0;
        c.opcode         = rd_op ? 7'b0000011 : (wr_op ? 7'b0100011 : 7'b0010011);
        c.funct3         = f3;
        c.mem_read       = rd_op;
        c.mem_write      = wr_op;
        c.load_regfile   = !wr_op;
        c.regfilemux_sel = 3'($urandom);
        MEM_valid_in = v;
        MEM_ctrl_in  = c;
        MEM_alu_in   = addr;
        MEM_rs2_in   = rs2;
        MEM_rd_in    = 5'($urandom);
        MEM_pc_in    = $urandom;
        MEM_u_imm_in = $urandom & 32'hFFFF_F000;
        for (int cnt = 0; ; cnt++) begin
            if (cnt > lat + 1) begin
                check_eq("op_timeout", 32'(cnt), 32'(lat));
                break;
            end
            dmem_resp  = (cnt == lat);
            dmem_rdata = (cnt == lat) ? rdata_v : $urandom;
            step();
            if (!exp_stall) break;
        end
        dmem_resp = 1'b0;
    endtask

    initial begin
        logic [31:0] wb_first;
        rst          = 1'b1;
        MEM_valid_in = 1'b0;
        MEM_ctrl_in  = '0;
        MEM_alu_in   = '0;
        MEM_rs2_in   = '0;
        MEM_rd_in    = '0;
        MEM_pc_in    = '0;
        MEM_u_imm_in = '0;
        dmem_rdata   = '0;
        dmem_resp    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("reset_stall", 32'(MEM_stall), 32'd0);
        check_wb();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // sw 0x100, three wait cycles
        drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 3);
        check_eq("sw_stall_cycles", perf_stall_cycles, 32'd3);
        check_eq("sw_mem_ops", perf_mem_ops, 32'd1);
        check_eq("sw_wb_valid", 32'(WB_valid), 32'd1);

        // lb 0x103, immediate response
        drive_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0);
        check_eq("lb_wb_mem", WB_mem, 32'h0000_0080);

        // sh 0x102
        drive_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 0);

        // misaligned lw 0x101
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 0);
        check_eq("mis_flag", 32'(WB_misaligned), 32'd1);
        check_eq("mis_load_regfile", 32'(WB_ctrl.load_regfile), 32'd0);

        // back-to-back lw/lw, one wait cycle each
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h1111_AAAA, 1);
        wb_first = WB_mem;
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h2222_BBBB, 1);
        check_eq("b2b_first", wb_first, 32'h1111_AAAA);
        check_eq("b2b_second", WB_mem, 32'h2222_BBBB);

        // reset during BUSY
        MEM_valid_in        = 1'b1;
        MEM_ctrl_in         = '0;
        MEM_ctrl_in.opcode  = 7'b0000011;
        MEM_ctrl_in.funct3  = 3'b010;
        MEM_ctrl_in.mem_read = 1'b1;
        MEM_ctrl_in.load_regfile = 1'b1;
        MEM_alu_in = 32'h300;
        dmem_resp  = 1'b0;
        step();
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_dmem_read", 32'(dmem_read), 32'd0);
        check_eq("rst_mem_stall", 32'(MEM_stall), 32'd0);
        check_wb();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 0);
        check_eq("post_rst_load", WB_mem, 32'hCAFE_F00D);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic v, rd_op, wr_op;
            logic [2:0] f3;
            int kind;
            v     = ($urandom_range(0, 7) != 0);
            kind  = $urandom_range(0, 2);
            rd_op = (kind == 0);
            wr_op = (kind == 1);
            if (rd_op) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else if (wr_op) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom);
            end
            drive_op(v, rd_op, wr_op, f3, $urandom, $urandom, $urandom,
                     $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
        $finish;
    end

endmodule
